expr_rpn_eval: RTL and testbench

Sequential evaluator for flattened expression trees. Consumes a postfix (RPN) token stream of constants and operators and evaluates it on an operand stack, one token per cycle. Returns a single result word with an error flag. Sits directly downstream of the expression elaborator and serves as the hardware golden model for operator semantics.

---
 rtl/expr_pkg.sv | 35 +++
 rtl/expr_alu.sv | 72 +++++++
 rtl/expr_rpn_eval.sv | 129 ++++++++++++
 tb/tb_expr_rpn_eval.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared token encodings, FSM states and sizing helper for the RPN evaluator.
package expr_pkg;

  typedef enum logic [1:0] {
    K_CONST  = 2'd0,
    K_UNARY  = 2'd1,
    K_BINARY = 2'd2,
    K_TERN   = 2'd3
  } tok_kind_e;

  typedef enum logic [4:0] {
    B_AND  = 5'd0,  B_OR   = 5'd1,  B_XOR  = 5'd2,  B_XNOR = 5'd3,
    B_LAND = 5'd4,  B_LOR  = 5'd5,  B_EQ   = 5'd6,  B_NEQ  = 5'd7,
    B_CEQ  = 5'd8,  B_CNEQ = 5'd9,  B_LT   = 5'd10, B_GT   = 5'd11,
    B_LEQ  = 5'd12, B_GEQ  = 5'd13, B_SHL  = 5'd14, B_SHR  = 5'd15,
    B_ASHL = 5'd16, B_ASHR = 5'd17, B_ADD  = 5'd18, B_SUB  = 5'd19
  } binop_e;

  typedef enum logic [4:0] {
    U_POS  = 5'd0, U_NEG  = 5'd1, U_NOT   = 5'd2, U_INV  = 5'd3, U_RAND  = 5'd4,
    U_ROR  = 5'd5, U_RXOR = 5'd6, U_RNAND = 5'd7, U_RNOR = 5'd8, U_RXNOR = 5'd9
  } unop_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Depth counter must represent 0..DEPTH inclusive.
  function automatic int ptr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/expr_alu.sv
// Combinational operator unit: unary f(a), binary a op b, ternary a ? b : c.
module expr_alu
  import expr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       kind,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             bad_op
);

  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  function automatic logic [WIDTH-1:0] zx(input logic x);
    return {{(WIDTH-1){1'b0}}, x};
  endfunction

  logic big_sh;
  assign big_sh = (b >= W_LIM);

  always_comb begin
    result = '0;
    bad_op = 1'b0;
    case (kind)
      K_CONST: result = a;
      K_UNARY: begin
        case (op)
          U_POS:   result = a;
          U_NEG:   result = -a;
          U_NOT:   result = zx(a == '0);
          U_INV:   result = ~a;
          U_RAND:  result = zx(&a);
          U_ROR:   result = zx(|a);
          U_RXOR:  result = zx(^a);
          U_RNAND: result = zx(~&a);
          U_RNOR:  result = zx(~|a);
          U_RXNOR: result = zx(~^a);
          default: bad_op = 1'b1;
        endcase
      end
      K_BINARY: begin
        case (op)
          B_AND:  result = a & b;
          B_OR:   result = a | b;
          B_XOR:  result = a ^ b;
          B_XNOR: result = ~(a ^ b);
          B_LAND: result = zx((a != '0) && (b != '0));
          B_LOR:  result = zx((a != '0) || (b != '0));
          B_EQ, B_CEQ:   result = zx(a == b);
          B_NEQ, B_CNEQ: result = zx(a != b);
          B_LT:   result = zx(a < b);
          B_GT:   result = zx(a > b);
          B_LEQ:  result = zx(a <= b);
          B_GEQ:  result = zx(a >= b);
          B_SHL, B_ASHL: result = big_sh ? '0 : (a << b);
          B_SHR:  result = big_sh ? '0 : (a >> b);
          // Oversized arithmetic shifts saturate to the sign fill.
          B_ASHR: result = big_sh ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
          B_ADD:  result = a + b;
          B_SUB:  result = a - b;
          default: bad_op = 1'b1;
        endcase
      end
      default: result = (a != '0) ? b : c;
    endcase
  end

endmodule

// File: rtl/expr_rpn_eval.sv
// Postfix token evaluator: operand stack plus RUN/DRAIN/DONE control, one token per cycle.
module expr_rpn_eval
  import expr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_kind,
  input  logic [4:0]       tok_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  localparam int PW = ptr_w(DEPTH);

  state_e                     state, state_n;
  logic [DEPTH-1:0][WIDTH-1:0] stk;
  logic [PW-1:0]              depth, depth_n, wr_idx, need;
  logic [WIDTH-1:0]           s0, s1, s2, alu_a, alu_b, alu_c, alu_res;
  logic [WIDTH-1:0]           res_data_n;
  logic                       res_err_n, alu_bad, wr_en, accept, is_end;

  assign tok_ready = (state != S_DONE);
  assign res_valid = (state == S_DONE);
  assign accept    = tok_valid & tok_ready;
  assign is_end    = (tok_kind == K_TERN) && tok_op[0];

  // s0 = top, s1 = next, s2 = third; garbage when depth is too shallow.
  always_comb begin
    s0 = '0;
    s1 = '0;
    s2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i) == depth - PW'(1)) s0 = stk[i];
      if (PW'(i) == depth - PW'(2)) s1 = stk[i];
      if (PW'(i) == depth - PW'(3)) s2 = stk[i];
    end
  end

  always_comb begin
    alu_a = s0;
    alu_b = '0;
    alu_c = '0;
    need  = '0;
    case (tok_kind)
      K_CONST:  alu_a = tok_data;
      K_UNARY:  need  = PW'(1);
      K_BINARY: begin alu_a = s1; alu_b = s0; need = PW'(2); end
      default:  begin alu_a = s2; alu_b = s1; alu_c = s0; need = is_end ? '0 : PW'(3); end
    endcase
  end

  expr_alu #(.WIDTH(WIDTH)) u_alu (
    .kind   (tok_kind),
    .op     (tok_op),
    .a      (alu_a),
    .b      (alu_b),
    .c      (alu_c),
    .result (alu_res),
    .bad_op (alu_bad)
  );

  always_comb begin
    state_n    = state;
    depth_n    = depth;
    wr_en      = 1'b0;
    wr_idx     = depth - need;
    res_data_n = res_data;
    res_err_n  = res_err;
    case (state)
      S_RUN: begin
        if (accept) begin
          if (is_end) begin
            state_n    = S_DONE;
            res_err_n  = (depth != PW'(1));
            res_data_n = (depth == PW'(1)) ? s0 : '0;
          end else if ((tok_kind == K_CONST && depth == PW'(DEPTH)) ||
                       (depth < need) || alu_bad) begin
            state_n   = S_DRAIN;
            res_err_n = 1'b1;
          end else begin
            wr_en   = 1'b1;
            depth_n = depth - need + PW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (accept && is_end) begin
          state_n    = S_DONE;
          res_err_n  = 1'b1;
          res_data_n = '0;
        end
      end
      default: begin
        if (res_ready) begin
          state_n    = S_RUN;
          depth_n    = '0;
          res_err_n  = 1'b0;
          res_data_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      depth    <= '0;
      stk      <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state    <= state_n;
      depth    <= depth_n;
      res_data <= res_data_n;
      res_err  <= res_err_n;
      for (int i = 0; i < DEPTH; i++)
        if (wr_en && PW'(i) == wr_idx) stk[i] <= alu_res;
    end
  end

endmodule

// File: tb/tb_expr_rpn_eval.sv
// Directed bench for expr_rpn_eval: hand-computed RPN programs with immediate-assertion checks.
module tb_expr_rpn_eval;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             tok_valid;
  logic             tok_ready;
  logic [1:0]       tok_kind;
  logic [4:0]       tok_op;
  logic [WIDTH-1:0] tok_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  int errors = 0;
  int checks = 0;

  expr_rpn_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_kind  (tok_kind),
    .tok_op    (tok_op),
    .tok_data  (tok_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks start and end at a falling edge.
  task automatic send(input logic [1:0] k, input logic [4:0] op, input logic [WIDTH-1:0] d);
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_op    = op;
    tok_data  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpush(input logic [WIDTH-1:0] d);
    send(2'd0, 5'd0, d);
  endtask

  task automatic finish_expr(input string tag, input logic [WIDTH-1:0] exp_d, input logic exp_e);
    int n;
    send(2'd3, 5'd1, '0);
    tok_valid = 1'b0;
    chk({tag, "_lat"}, res_valid, 1);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_data"}, res_data, exp_d);
    chk({tag, "_err"}, res_err, exp_e);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_rv_clr"}, res_valid, 0);
    chk({tag, "_rdy"}, tok_ready, 1);
  endtask

  initial begin
    rst = 1'b1; tok_valid = 1'b0; tok_kind = '0; tok_op = '0; tok_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tok_ready", tok_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    rst = 1'b0;

    // 5 - 3 = 2
    cpush(8'd5); cpush(8'd3); send(2'd2, 5'd19, '0);
    finish_expr("sub", 8'd2, 1'b0);

    // Oversized shifts
    cpush(8'h80); cpush(8'd9); send(2'd2, 5'd17, '0);
    finish_expr("ashr9", 8'hFF, 1'b0);
    cpush(8'h80); cpush(8'd9); send(2'd2, 5'd15, '0);
    finish_expr("shr9", 8'h00, 1'b0);
    cpush(8'h90); cpush(8'd2); send(2'd2, 5'd17, '0);
    finish_expr("ashr2", 8'hE4, 1'b0);

    // Ternary select
    cpush(8'd1); cpush(8'd7); cpush(8'd9); send(2'd3, 5'd0, '0);
    finish_expr("tern1", 8'd7, 1'b0);
    cpush(8'd0); cpush(8'd7); cpush(8'd9); send(2'd3, 5'd0, '0);
    finish_expr("tern0", 8'd9, 1'b0);

    // Misc binary ops
    cpush(8'd3); cpush(8'd5); send(2'd2, 5'd10, '0);
    finish_expr("lt", 8'd1, 1'b0);
    cpush(8'h0F); cpush(8'h3C); send(2'd2, 5'd3, '0);
    finish_expr("xnor", 8'hCC, 1'b0);

    // Overflow: DEPTH+1 pushes, then tokens drained until END
    for (int i = 0; i <= DEPTH; i++) cpush(8'(i + 1));
    chk("drain_rdy", tok_ready, 1);
    send(2'd2, 5'd18, '0);
    finish_expr("ovf", 8'h00, 1'b1);

    // Underflow, bad opcode, END with depth 0 or 2
    cpush(8'd4); send(2'd2, 5'd10, '0);
    finish_expr("unf", 8'h00, 1'b1);
    cpush(8'd4); send(2'd1, 5'd12, '0);
    finish_expr("badop", 8'h00, 1'b1);
    finish_expr("empty", 8'h00, 1'b1);
    cpush(8'd1); cpush(8'd2);
    finish_expr("depth2", 8'h00, 1'b1);

    // Result held while res_ready low; tokens offered in DONE are ignored
    cpush(8'd6); send(2'd1, 5'd3, '0); send(2'd3, 5'd1, '0);
    tok_valid = 1'b1; tok_kind = 2'd0; tok_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, 8'hF9);
      chk("hold_rdy", tok_ready, 0);
      @(negedge clk);
    end
    tok_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("hold_rv_clr", res_valid, 0);
    cpush(8'd5); cpush(8'd3); send(2'd2, 5'd18, '0);
    finish_expr("post_hold", 8'd8, 1'b0);

    // Reset mid-expression
    cpush(8'd1); cpush(8'd2); cpush(8'd3);
    tok_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rdy", tok_ready, 1);
    chk("mid_rst_rv", res_valid, 0);
    cpush(8'd4); send(2'd1, 5'd6, '0);
    finish_expr("rxor", 8'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
